// File: rtl/ram_access_arbiter.sv
// Two-port arbiter and three-phase strobe sequencer for random_access_memory.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority to A.
module ram_access_arbiter #(
   parameter int SIZE = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            a_req,
   input  logic            a_we,
   input  logic [SIZE-1:0] a_addr,
   input  logic [SIZE-1:0] a_wdata,
   output logic            a_ack,
   output logic [SIZE-1:0] a_rdata,
   input  logic            b_req,
   input  logic            b_we,
   input  logic [SIZE-1:0] b_addr,
   input  logic [SIZE-1:0] b_wdata,
   output logic            b_ack,
   output logic [SIZE-1:0] b_rdata,
   output logic [SIZE-1:0] ram_address,
   output logic            ram_set_address,
   output logic            ram_set,
   output logic            ram_enable,
   output logic [SIZE-1:0] ram_data_in,
   input  logic [SIZE-1:0] ram_data_out,
   output logic            busy,
   output logic            owner
);

   typedef enum logic [1:0] {IDLE, ADDR, XFER, CAPT} state_t;

   state_t          state_q, state_d;
   logic            we_q, we_d;
   logic [SIZE-1:0] addr_q, addr_d;
   logic [SIZE-1:0] wdata_q, wdata_d;
   logic            owner_q, owner_d;
   logic            grantB;

   logic [SIZE-1:0] ramAddress_q, ramAddress_d;
   logic            ramSetAddress_q, ramSetAddress_d;
   logic            ramSet_q, ramSet_d;
   logic            ramEnable_q, ramEnable_d;
   logic [SIZE-1:0] ramDataIn_q, ramDataIn_d;
   logic            aAck_q, aAck_d;
   logic            bAck_q, bAck_d;
   logic [SIZE-1:0] aRdata_q, aRdata_d;
   logic [SIZE-1:0] bRdata_q, bRdata_d;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   // Remembers which port won the previous grant; resets to B so A wins the first tie.
   logic lastB_q, lastB_d;

   always_comb begin
      grantB  = b_req && (!a_req || !lastB_q);
      lastB_d = lastB_q;
      if (state_q == IDLE && (a_req || b_req)) begin
         lastB_d = grantB;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lastB_q <= 1'b1;
      end else begin
         lastB_q <= lastB_d;
      end
   end
`else
   always_comb begin
      grantB = b_req && !a_req;
   end
`endif

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      owner_d = owner_q;
      case (state_q)
         IDLE: begin
            if (a_req || b_req) begin
               state_d = ADDR;
               owner_d = grantB;
               we_d    = grantB ? b_we    : a_we;
               addr_d  = grantB ? b_addr  : a_addr;
               wdata_d = grantB ? b_wdata : a_wdata;
            end
         end
         ADDR:    state_d = XFER;
         XFER:    state_d = CAPT;
         CAPT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // RAM strobes and acks are decoded from the next state so they leave flops cleanly.
   always_comb begin
      ramAddress_d    = ramAddress_q;
      ramSetAddress_d = 1'b0;
      ramSet_d        = 1'b0;
      ramEnable_d     = 1'b0;
      ramDataIn_d     = ramDataIn_q;
      aAck_d          = 1'b0;
      bAck_d          = 1'b0;
      case (state_d)
         ADDR: begin
            ramAddress_d    = addr_d;
            ramSetAddress_d = 1'b1;
         end
         XFER: begin
            ramEnable_d = 1'b1;
            ramSet_d    = we_q;
            ramDataIn_d = wdata_q;
         end
         CAPT: begin
            aAck_d = !owner_q;
            bAck_d = owner_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      aRdata_d = aRdata_q;
      bRdata_d = bRdata_q;
      if (state_q == CAPT && !we_q) begin
         if (owner_q) begin
            bRdata_d = ram_data_out;
         end else begin
            aRdata_d = ram_data_out;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         we_q            <= 1'b0;
         addr_q          <= '0;
         wdata_q         <= '0;
         owner_q         <= 1'b0;
         ramAddress_q    <= '0;
         ramSetAddress_q <= 1'b0;
         ramSet_q        <= 1'b0;
         ramEnable_q     <= 1'b0;
         ramDataIn_q     <= '0;
         aAck_q          <= 1'b0;
         bAck_q          <= 1'b0;
         aRdata_q        <= '0;
         bRdata_q        <= '0;
      end else begin
         state_q         <= state_d;
         we_q            <= we_d;
         addr_q          <= addr_d;
         wdata_q         <= wdata_d;
         owner_q         <= owner_d;
         ramAddress_q    <= ramAddress_d;
         ramSetAddress_q <= ramSetAddress_d;
         ramSet_q        <= ramSet_d;
         ramEnable_q     <= ramEnable_d;
         ramDataIn_q     <= ramDataIn_d;
         aAck_q          <= aAck_d;
         bAck_q          <= bAck_d;
         aRdata_q        <= aRdata_d;
         bRdata_q        <= bRdata_d;
      end
   end

   assign ram_address     = ramAddress_q;
   assign ram_set_address = ramSetAddress_q;
   assign ram_set         = ramSet_q;
   assign ram_enable      = ramEnable_q;
   assign ram_data_in     = ramDataIn_q;
   assign a_ack           = aAck_q;
   assign b_ack           = bAck_q;
   assign a_rdata         = aRdata_q;
   assign b_rdata         = bRdata_q;
   assign busy            = (state_q != IDLE);
   assign owner           = owner_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed scoreboard bench for ram_access_arbiter with a behavioural RAM attached.
// Tie expectations follow RAM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_ram_access_arbiter;

   localparam int SIZE = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            a_req, a_we, b_req, b_we;
   logic [SIZE-1:0] a_addr, a_wdata, b_addr, b_wdata;
   logic            a_ack, b_ack;
   logic [SIZE-1:0] a_rdata, b_rdata;
   logic [SIZE-1:0] ram_address, ram_data_in, ram_data_out;
   logic            ram_set_address, ram_set, ram_enable;
   logic            busy, owner;

   typedef struct {
      logic            port;
      logic            we;
      logic [SIZE-1:0] addr;
      logic [SIZE-1:0] data;
   } txn_t;

   txn_t            sb[$];
   logic [SIZE-1:0] refMem [256];
   logic [SIZE-1:0] mem [256];
   logic [SIZE-1:0] ramDataOut_q;
   logic [SIZE-1:0] aRdataExp, bRdataExp;
   int              checks = 0;
   int              errors = 0;

   ram_access_arbiter #(.SIZE(SIZE)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .ram_address(ram_address), .ram_set_address(ram_set_address),
      .ram_set(ram_set), .ram_enable(ram_enable),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
      .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   // Simple synchronous RAM: writes and read captures happen on enabled edges.
   always @(posedge clk) begin
      if (ram_enable) begin
         if (ram_set) mem[ram_address] <= ram_data_in;
         else         ramDataOut_q     <= mem[ram_address];
      end
   end
   assign ram_data_out = ramDataOut_q;

   task automatic checkOutput(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pushTxn(input logic port, input logic we, input logic [SIZE-1:0] addr, input logic [SIZE-1:0] wdata);
      txn_t t;
      t.port = port;
      t.we   = we;
      t.addr = addr;
      if (we) begin
         refMem[addr] = wdata;
         t.data = wdata;
      end else begin
         t.data = refMem[addr];
      end
      sb.push_back(t);
   endtask

   // Runs one transaction from one port with per-phase strobe checks.
   task automatic applyStimulus(input logic port, input logic we, input logic [SIZE-1:0] addr,
                                input logic [SIZE-1:0] wdata, input bit changeAddr);
      txn_t exp;
      bit   got;
      @(negedge clk);
      if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
      else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
      pushTxn(port, we, addr, wdata);
      @(posedge clk); #1;
      checkOutput("addr set_address", {7'd0, ram_set_address}, 8'd1);
      checkOutput("addr ram_address", ram_address, addr);
      checkOutput("addr enable", {7'd0, ram_enable}, 8'd0);
      checkOutput("addr busy", {7'd0, busy}, 8'd1);
      checkOutput("addr owner", {7'd0, owner}, {7'd0, port});
      if (changeAddr) a_addr = 8'd7;
      @(posedge clk); #1;
      checkOutput("xfer set_address", {7'd0, ram_set_address}, 8'd0);
      checkOutput("xfer enable", {7'd0, ram_enable}, 8'd1);
      checkOutput("xfer set", {7'd0, ram_set}, {7'd0, we});
      checkOutput("xfer ram_address", ram_address, addr);
      if (we) checkOutput("xfer data_in", ram_data_in, wdata);
      got = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (a_ack || b_ack) begin got = 1; break; end
      end
      checkOutput("ack seen", {7'd0, got}, 8'd1);
      if (sb.size() == 0) begin
         checkOutput("scoreboard empty", 8'd1, 8'd0);
         return;
      end
      exp = sb.pop_front();
      checkOutput("capt a_ack", {7'd0, a_ack}, {7'd0, !exp.port});
      checkOutput("capt b_ack", {7'd0, b_ack}, {7'd0, exp.port});
      checkOutput("capt enable", {7'd0, ram_enable}, 8'd0);
      checkOutput("capt ram_address", ram_address, exp.addr);
      @(posedge clk); #1;
      a_req = 0;
      b_req = 0;
      if (!exp.we) begin
         if (exp.port) bRdataExp = exp.data;
         else          aRdataExp = exp.data;
      end
      checkOutput("a_rdata", a_rdata, aRdataExp);
      checkOutput("b_rdata", b_rdata, bRdataExp);
      checkOutput("idle busy", {7'd0, busy}, 8'd0);
      checkOutput("idle ack", {6'd0, a_ack, b_ack}, 8'd0);
   endtask

   initial begin
      txn_t exp;
      int   ackCount;
      int   bAckCount;
      for (int i = 0; i < 256; i++) begin
         mem[i]    = '0;
         refMem[i] = '0;
      end
      ramDataOut_q = '0;
      aRdataExp = '0;
      bRdataExp = '0;
      rst_n = 0; a_req = 1; a_we = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;

      // Reset with A requesting: everything must read back zero.
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset busy", {7'd0, busy}, 8'd0);
      checkOutput("reset acks", {6'd0, a_ack, b_ack}, 8'd0);
      checkOutput("reset strobes", {5'd0, ram_set_address, ram_set, ram_enable}, 8'd0);
      checkOutput("reset ram_address", ram_address, 8'd0);
      checkOutput("reset ram_data_in", ram_data_in, 8'd0);
      checkOutput("reset a_rdata", a_rdata, 8'd0);
      checkOutput("reset b_rdata", b_rdata, 8'd0);
      checkOutput("reset owner", {7'd0, owner}, 8'd0);
      a_req = 0;
      rst_n = 1;

      applyStimulus(1'b0, 1'b1, 8'd3, 8'hAA, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'd3, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'd5, 8'h55, 1'b0);
      applyStimulus(1'b1, 1'b0, 8'd5, 8'h00, 1'b0);
      checkOutput("owner after B", {7'd0, owner}, 8'd1);

      // Both ports hold read requests; the grant order depends on the tie policy.
      @(negedge clk);
      a_req = 1; a_we = 0; a_addr = 8'd3;
      b_req = 1; b_we = 0; b_addr = 8'd5;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      pushTxn(1'b0, 1'b0, 8'd3, 8'd0);
      pushTxn(1'b1, 1'b0, 8'd5, 8'd0);
      pushTxn(1'b0, 1'b0, 8'd3, 8'd0);
      pushTxn(1'b1, 1'b0, 8'd5, 8'd0);
`else
      for (int i = 0; i < 4; i++) pushTxn(1'b0, 1'b0, 8'd3, 8'd0);
`endif
      ackCount = 0;
      bAckCount = 0;
      for (int cyc = 0; cyc < 40 && ackCount < 4; cyc++) begin
         @(negedge clk);
         if (a_ack || b_ack) begin
            ackCount++;
            if (b_ack) bAckCount++;
            exp = sb.pop_front();
            checkOutput("tie grant port", {6'd0, a_ack, b_ack}, exp.port ? 8'd1 : 8'd2);
            @(posedge clk); #1;
            if (exp.port) bRdataExp = exp.data;
            else          aRdataExp = exp.data;
            checkOutput("tie a_rdata", a_rdata, aRdataExp);
            checkOutput("tie b_rdata", b_rdata, bRdataExp);
            if (ackCount == 4) begin a_req = 0; b_req = 0; end
         end
      end
      a_req = 0;
      b_req = 0;
      checkOutput("tie ack count", ackCount[7:0], 8'd4);
`ifdef RAM_ARB_ROUND_ROBIN_EN
      checkOutput("tie b acks", bAckCount[7:0], 8'd2);
`else
      checkOutput("tie b acks", bAckCount[7:0], 8'd0);
`endif
      sb.delete();
      repeat (2) @(posedge clk);

      // Address moves after the grant; the latched address must stick.
      applyStimulus(1'b0, 1'b1, 8'd2, 8'h3C, 1'b1);
      checkOutput("mem[2] written", mem[2], 8'h3C);
      checkOutput("mem[7] untouched", mem[7], 8'h00);

      // Reset during XFER of an A write: no ack, but the RAM write lands.
      @(negedge clk);
      a_req = 1; a_we = 1; a_addr = 8'd9; a_wdata = 8'h11;
      refMem[9] = 8'h11;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("pre-reset xfer enable", {7'd0, ram_enable}, 8'd1);
      rst_n = 0;
      a_req = 0;
      @(posedge clk); #1;
      aRdataExp = '0;
      bRdataExp = '0;
      checkOutput("midreset busy", {7'd0, busy}, 8'd0);
      checkOutput("midreset a_ack", {7'd0, a_ack}, 8'd0);
      checkOutput("midreset strobes", {5'd0, ram_set_address, ram_set, ram_enable}, 8'd0);
      checkOutput("midreset b_rdata", b_rdata, 8'd0);
      @(negedge clk);
      rst_n = 1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("no ack after reset", {6'd0, a_ack, b_ack}, 8'd0);
      end
      applyStimulus(1'b0, 1'b0, 8'd9, 8'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
